// File: rtl/imm_gen_stage.sv
// RISC-V immediate extraction stage with a 2-entry (main + skid) output buffer.
// Latency 1 cycle; in_ready comes from a flop, so it never depends combinationally on out_ready.
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic [15:0]      illegal_cnt
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } res_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t      st, st_nxt;
  res_t        dec, main_q, skid_q;
  logic        rdy_q;
  logic [15:0] cnt_q;
  logic        in_xfer, out_xfer;
  logic        load_main, load_skid, move_skid;

  // The opcode field plays no part in any immediate format.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    dec     = '0;
    dec.tag = in_tag;
    case (imm_src)
      3'b000: dec.imm = XLEN'($signed(instr[31:20]));
      3'b001: dec.imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      3'b010: dec.imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      3'b011: dec.imm = XLEN'($signed({instr[31:12], 12'b0}));
      3'b100: dec.imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      3'b101: begin
        if (XLEN == 64) dec.imm = XLEN'(instr[25:20]);
        else            dec.imm = XLEN'(instr[24:20]);
      end
      default: dec.ill = 1'b1;
    endcase
  end

  assign in_ready  = rdy_q;
  assign out_valid = (st != EMPTY);
  assign in_xfer   = in_valid & rdy_q;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    st_nxt    = st;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (st)
      EMPTY: if (in_xfer) begin
        load_main = 1'b1;
        st_nxt    = ONE;
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          load_skid = 1'b1;
          st_nxt    = FULL;
        end else if (out_xfer) begin
          st_nxt    = EMPTY;
        end
      end
      FULL: if (out_xfer) begin
        move_skid = 1'b1;
        st_nxt    = ONE;
      end
      default: st_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= EMPTY;
      rdy_q  <= 1'b1;
      main_q <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else begin
      st    <= st_nxt;
      rdy_q <= (st_nxt != FULL);
      if (load_main)      main_q <= dec;
      else if (move_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= dec;
      if (in_xfer && dec.ill && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign imm         = main_q.imm;
  assign out_tag     = main_q.tag;
  assign out_illegal = main_q.ill;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench for imm_gen_stage: directed vectors, backpressure, saturation,
// reset-while-full and randomized traffic against a queue-based reference model.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32;
  logic [4:0]  tag32;
  logic [15:0] cnt32;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64;
  logic [4:0]  tag64;
  logic [15:0] cnt64;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .TAG_W(5)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .instr(instr),
    .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .imm(imm32), .out_tag(tag32), .out_illegal(ill32), .illegal_cnt(cnt32));

  imm_gen_stage #(.XLEN(64), .TAG_W(5)) u64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64), .instr(instr),
    .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .imm(imm64), .out_tag(tag64), .out_illegal(ill64), .illegal_cnt(cnt64));

  // Reference decode from the format tables: assemble the field arithmetically, then sign-extend.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src, input int xlen);
    longint f;
    int     w;
    logic [63:0] r;
    w = 0;
    f = 0;
    case (src)
      3'd0: begin f = longint'(ins[31:20]); w = 12; end
      3'd1: begin f = longint'(ins[31:25]) * 32 + longint'(ins[11:7]); w = 12; end
      3'd2: begin f = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                      longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2; w = 13; end
      3'd3: begin f = longint'(ins[31:12]) * 4096; w = 32; end
      3'd4: begin f = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
                      longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2; w = 21; end
      3'd5: f = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      default: f = 0;
    endcase
    if (w != 0 && f >= (longint'(1) <<< (w - 1))) f = f - (longint'(1) <<< w);
    r = f;
    if (xlen == 32) r = {32'b0, r[31:0]};
    return r;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; instr = '0; imm_src = '0; in_tag = '0; out_ready = 1'b0;
    #12;
    n_checks++;
    if (out_valid32 !== 1'b0 || imm32 !== 32'h0 || tag32 !== 5'h0 || ill32 !== 1'b0 || cnt32 !== 16'h0)
      $display("FAIL reset_outputs: ov=%b imm=%h tag=%h ill=%b cnt=%h, want all zero", out_valid32, imm32, tag32, ill32, cnt32);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready32 !== 1'b1 || in_ready64 !== 1'b1 || out_valid32 !== 1'b0)
      $display("FAIL reset_release: in_ready=%b/%b out_valid=%b, want 1/1/0", in_ready32, in_ready64, out_valid32);
    else n_pass++;
  endtask

  task automatic test_vectors();
    logic [31:0] vi [5] = '{32'hFFF00093, 32'hFE000EE3, 32'h0080006F, 32'h800000B7, 32'h03F01093};
    logic [2:0]  vs [5] = '{3'd0, 3'd2, 3'd4, 3'd3, 3'd5};
    logic [31:0] e32 [5] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000008, 32'h80000000, 32'h0000001F};
    logic [63:0] e64 [5] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h8,
                             64'hFFFFFFFF80000000, 64'h3F};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; instr = vi[i]; imm_src = vs[i]; in_tag = 5'(i + 4);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if (out_valid32 !== 1'b1 || imm32 !== e32[i] || tag32 !== 5'(i + 4) || ill32 !== 1'b0)
        $display("FAIL vec32_%0d: ov=%b imm=%h tag=%0d ill=%b, want ov=1 imm=%h tag=%0d ill=0",
                 i, out_valid32, imm32, tag32, ill32, e32[i], i + 4);
      else n_pass++;
      n_checks++;
      if (out_valid64 !== 1'b1 || imm64 !== e64[i])
        $display("FAIL vec64_%0d: ov=%b imm=%h, want ov=1 imm=%h", i, out_valid64, imm64, e64[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00100093; imm_src = 3'd0;
    in_tag = 5'd1;
    @(negedge clk);
    n_checks++;
    if (in_ready32 !== 1'b1) $display("FAIL bp_push1_ready: in_ready=%b, want 1", in_ready32); else n_pass++;
    @(posedge clk); #1;
    in_tag = 5'd2;
    @(negedge clk);
    n_checks++;
    if (in_ready32 !== 1'b1) $display("FAIL bp_push2_ready: in_ready=%b, want 1", in_ready32); else n_pass++;
    @(posedge clk); #1;
    in_tag = 5'd3; imm_src = 3'd6;
    @(negedge clk);
    n_checks++;
    if (in_ready32 !== 1'b0 || tag32 !== 5'd1) $display("FAIL bp_full: in_ready=%b tag=%0d, want 0 and 1", in_ready32, tag32); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (in_ready32 !== 1'b0 || cnt32 !== 16'd0 || tag32 !== 5'd1)
      $display("FAIL bp_blocked: in_ready=%b cnt=%0d tag=%0d, want 0,0,1", in_ready32, cnt32, tag32);
    else n_pass++;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (tag32 !== 5'd2 || in_ready32 !== 1'b1 || out_valid32 !== 1'b1)
      $display("FAIL bp_second: tag=%0d in_ready=%b ov=%b, want 2,1,1", tag32, in_ready32, out_valid32);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tag32 !== 5'd3 || ill32 !== 1'b1 || imm32 !== 32'h0 || cnt32 !== 16'd1)
      $display("FAIL bp_third: tag=%0d ill=%b imm=%h cnt=%0d, want 3,1,0,1", tag32, ill32, imm32, cnt32);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid32 !== 1'b0) $display("FAIL bp_drain: out_valid=%b, want 0", out_valid32); else n_pass++;
  endtask

  task automatic test_illegal_sat();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'hFFFFFFFF; imm_src = 3'd6; in_tag = 5'd9;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (imm32 !== 32'h0 || imm64 !== 64'h0 || ill32 !== 1'b1 || cnt32 !== 16'd1)
      $display("FAIL illegal_first: imm=%h/%h ill=%b cnt=%0d, want 0/0,1,1", imm32, imm64, ill32, cnt32);
    else n_pass++;
    imm_src = 3'd7;
    repeat (65533) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (cnt32 !== 16'hFFFE) $display("FAIL illegal_fffe: cnt=%h, want fffe", cnt32); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (cnt32 !== 16'hFFFF || cnt64 !== 16'hFFFF)
        $display("FAIL illegal_sat_%0d: cnt=%h/%h, want ffff", i, cnt32, cnt64);
      else n_pass++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_full();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h12345678; imm_src = 3'd6; in_tag = 5'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (in_ready32 !== 1'b0 || out_valid32 !== 1'b1 || cnt32 !== 16'd2)
      $display("FAIL rstfull_pre: in_ready=%b ov=%b cnt=%0d, want 0,1,2", in_ready32, out_valid32, cnt32);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid32 !== 1'b0 || cnt32 !== 16'd0 || ill32 !== 1'b0 || tag32 !== 5'd0 || out_valid64 !== 1'b0)
      $display("FAIL rstfull_async: ov=%b cnt=%0d ill=%b tag=%0d, want all 0", out_valid32, cnt32, ill32, tag32);
    else n_pass++;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0)
      $display("FAIL rstfull_release: in_ready=%b ov=%b, want 1,0", in_ready32, out_valid32);
    else n_pass++;
  endtask

  typedef struct {
    logic [31:0] e32;
    logic [63:0] e64;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  task automatic test_random();
    exp_t        q[$];
    exp_t        e;
    logic [15:0] cnt_m;
    int          errs;
    logic        in_x, out_x;
    do_reset();
    cnt_m = 0;
    errs  = 0;
    in_valid = 1'b0; out_ready = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready32 !== (q.size() < 2) || in_ready64 !== (q.size() < 2) ||
          out_valid32 !== (q.size() > 0) || out_valid64 !== (q.size() > 0) ||
          cnt32 !== cnt_m || cnt64 !== cnt_m) begin
        if (errs < 10)
          $display("FAIL rand_flow cyc %0d: in_ready=%b ov=%b cnt=%0d, want %b %b %0d",
                   cyc, in_ready32, out_valid32, cnt32, q.size() < 2, q.size() > 0, cnt_m);
        errs++;
      end else n_pass++;
      in_x  = in_valid && (q.size() < 2);
      out_x = out_ready && (q.size() > 0);
      if (out_x) begin
        e = q.pop_front();
        n_checks++;
        if (imm32 !== e.e32 || imm64 !== e.e64 || tag32 !== e.tag || tag64 !== e.tag ||
            ill32 !== e.ill || ill64 !== e.ill) begin
          if (errs < 10)
            $display("FAIL rand_data cyc %0d: imm=%h/%h tag=%0d ill=%b, want %h/%h %0d %b",
                     cyc, imm32, imm64, tag32, ill32, e.e32, e.e64, e.tag, e.ill);
          errs++;
        end else n_pass++;
      end
      if (in_x) begin
        e.e64 = ref_imm(instr, imm_src, 64);
        e.e32 = ref_imm(instr, imm_src, 32) & 64'hFFFFFFFF;
        e.tag = in_tag;
        e.ill = (imm_src >= 3'd6);
        q.push_back(e);
        if (e.ill && cnt_m != 16'hFFFF) cnt_m = cnt_m + 1;
      end
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      instr     = $urandom;
      imm_src   = 3'($urandom_range(0, 7));
      in_tag    = 5'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_full();
    test_random();
    test_illegal_sat();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 Parameter XLEN SHALL default to 32, SHALL accept only 32 or 64, and SHALL set the immediate output width.
REQ-002 Parameter TAG_W SHALL default to 5 and SHALL set the width of the sideband tag that passes through unmodified.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  upstream presents an instruction.
REQ-006 in_ready  output  1  stage can accept; an input transfer occurs when in_valid & in_ready.
REQ-007 instr  input  32  raw instruction word.
REQ-008 imm_src  input  3  immediate format select.
REQ-009 in_tag  input  TAG_W  sideband tag (e.g. rd/PC index).
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  downstream accepts; an output transfer occurs when out_valid & out_ready.
REQ-012 imm  output  XLEN  extended immediate.
REQ-013 out_tag  output  TAG_W  tag paired with imm.
REQ-014 out_illegal  output  1  result came from an illegal imm_src.
REQ-015 illegal_cnt  output  16  saturating count of accepted illegal encodings.

Function
REQ-016 Decode: 000 I = sext(instr[31:20]).
REQ-017 Decode: 001 S = sext({instr[31:25], instr[11:7]}).
REQ-018 Decode: 010 B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
REQ-019 Decode: 011 U = sext({instr[31:12], 12'b0}); for XLEN=64, bits 63:32 are copies of instr[31].
REQ-020 Decode: 100 J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
REQ-021 Decode: 101 SHAMT = zero-extended instr[24:20] when XLEN=32, and zero-extended instr[25:20] when XLEN=64.
REQ-022 Decode: 110/111 are illegal; they SHALL produce imm = 0 and out_illegal = 1.
REQ-023 Sign extension SHALL always fill up to XLEN from the top bit of the assembled field.
REQ-024 Decode SHALL be registered: an accepted input appears on the outputs at earliest one cycle after the input transfer.
REQ-025 Buffering SHALL be 2 entries: a main output register plus a skid register.
REQ-026 The buffer SHALL have states EMPTY, ONE and FULL.
REQ-027 EMPTY: in_ready=1 and out_valid=0; an input transfer moves the state to ONE.
REQ-028 ONE: in_ready=1 and out_valid=1.
REQ-029 ONE, input and output transfer in the same cycle: state stays ONE and the main register loads the new result.
REQ-030 ONE, input transfer only: state goes to FULL and the result goes to the skid register.
REQ-031 ONE, output transfer only: state goes to EMPTY.
REQ-032 FULL: in_ready=0; an output transfer moves the skid entry into the main register and the state goes to ONE.
REQ-033 in_ready SHALL be driven directly from a state register, not combinationally from out_ready.
REQ-034 While out_valid=1 and out_ready=0, imm, out_tag and out_illegal SHALL hold stable.
REQ-035 Ordering SHALL be strictly FIFO.
REQ-036 illegal_cnt SHALL increment by 1 on each input transfer whose imm_src is 110 or 111.
REQ-037 illegal_cnt SHALL saturate at 0xFFFF.
REQ-038 in_valid without in_ready SHALL have no effect, including no change to illegal_cnt.

Reset
REQ-039 Asserting rst SHALL immediately force state EMPTY, out_valid=0, imm=0, out_tag=0, out_illegal=0 and illegal_cnt=0.
REQ-040 in_ready SHALL read 1 from the first cycle after rst deasserts.
REQ-041 Reset in any state, including mid-FULL, SHALL discard all buffered entries.

Verification
REQ-042 XLEN=32, instr 0xFFF00093, src 000, out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF.
REQ-043 XLEN=32, instr 0xFE000EE3, src 010 -> imm=0xFFFFFFFC; instr 0x0080006F, src 100 -> imm=0x00000008.
REQ-044 XLEN=64, instr 0x800000B7, src 011 -> imm=0xFFFFFFFF80000000; instr 0x03F01093, src 101 -> imm=0x3F.
REQ-045 out_ready=0, push tags 1,2,3 on consecutive cycles -> tags 1,2 accepted, in_ready=0 at third push; then raise out_ready -> outputs tag 1,2 in order, and tag 3 is accepted the cycle after in_ready returns to 1.
REQ-046 src 110 accepted -> imm=0, out_illegal=1, illegal_cnt 0->1; after 0x10000 illegal transfers -> illegal_cnt=0xFFFF.
REQ-047 Assert rst while FULL -> out_valid=0, illegal_cnt=0 the same cycle; in_ready=1 after release.
